sm3_msg_expand: RTL and testbench

- SM3 message-expansion producer for the SM3 compression core.
- Accepts one padded 512-bit message block and generates the expanded words Wj (j=0..67) and W'j (j=0..63).
- Delivers them four steps at a time, tagged with step counter s = 0,4,...,60, which the compression core consumes.
- The block sits between the padding/message buffer and the compression core. It uses a valid/ready handshake on both sides.

---
 rtl/sm3_msg_expand.sv | 127 ++++++++++++
 tb/tb_sm3_msg_expand.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sm3_msg_expand.sv
// sm3_msg_expand: SM3 message-expansion producer.
// Takes one padded 512-bit block and streams Wj (j=0..67) and W'j (j=0..63)
// to the compression core, four steps per beat, tagged with step index s.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   blk_valid/blk_ready   block handshake; blk_data holds W0 in [511:480]
//   out_valid/out_ready   beat handshake toward the compression core
//   s                     step index of WJ_0/fj_0 (0,4..60; 64 in DONE)
//   WJ_0..WJ_3            Wj for j = s..s+3
//   fj_0..fj_3            W'j = Wj ^ Wj+4 for j = s..s+3
//   done                  one-cycle pulse after the final beat is accepted
module sm3_msg_expand #(
    parameter int STEPS_PER_BEAT = 4,
    parameter int LAST_STEP      = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    input  logic [511:0] blk_data,
    output logic         blk_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [6:0]   s,
    output logic [31:0]  WJ_0,
    output logic [31:0]  WJ_1,
    output logic [31:0]  WJ_2,
    output logic [31:0]  WJ_3,
    output logic [31:0]  fj_0,
    output logic [31:0]  fj_1,
    output logic [31:0]  fj_2,
    output logic [31:0]  fj_3,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state, state_d;
    logic [31:0] win [16];
    logic [31:0] n16, n17, n18, n19;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // Wk from (Wk-16, Wk-9, Wk-3, Wk-13, Wk-6)
    function automatic logic [31:0] nxt(input logic [31:0] a16, input logic [31:0] a9,
                                        input logic [31:0] a3, input logic [31:0] a13,
                                        input logic [31:0] a6);
        return p1(a16 ^ a9 ^ rotl(a3, 15)) ^ rotl(a13, 7) ^ a6;
    endfunction

    // Window holds W[s..s+15]; W[s+19] needs W[s+16] from this same cycle.
    assign n16 = nxt(win[0], win[7],  win[13], win[3], win[10]);
    assign n17 = nxt(win[1], win[8],  win[14], win[4], win[11]);
    assign n18 = nxt(win[2], win[9],  win[15], win[5], win[12]);
    assign n19 = nxt(win[3], win[10], n16,     win[6], win[13]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        blk_ready = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) state_d = RUN;
            end
            RUN: begin
                out_valid = 1'b1;
                if (out_ready && s == 7'(LAST_STEP)) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            case (state)
                IDLE: if (blk_valid) begin
                    s <= '0;
                    for (int i = 0; i < 16; i++) win[i] <= blk_data[511 - 32*i -: 32];
                end
                RUN: if (out_ready) begin
                    if (s == 7'(LAST_STEP)) begin
                        s <= 7'(LAST_STEP + STEPS_PER_BEAT);
                    end else begin
                        s <= s + 7'(STEPS_PER_BEAT);
                        for (int i = 0; i < 12; i++) win[i] <= win[i+4];
                        win[12] <= n16;
                        win[13] <= n17;
                        win[14] <= n18;
                        win[15] <= n19;
                    end
                end
                FIN: s <= '0;
                default: ;
            endcase
        end
    end

    assign WJ_0 = win[0];
    assign WJ_1 = win[1];
    assign WJ_2 = win[2];
    assign WJ_3 = win[3];
    assign fj_0 = win[0] ^ win[4];
    assign fj_1 = win[1] ^ win[5];
    assign fj_2 = win[2] ^ win[6];
    assign fj_3 = win[3] ^ win[7];

endmodule

// File: tb/tb_sm3_msg_expand.sv
// tb_sm3_msg_expand: directed and random checks of sm3_msg_expand against a
// straight-line software expansion of W0..W67.
module tb_sm3_msg_expand;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [6:0]   s;
    logic [31:0]  WJ_0, WJ_1, WJ_2, WJ_3, fj_0, fj_1, fj_2, fj_3;
    logic         done;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int blocks_done = 0;

    logic [31:0] gw  [0:67];
    logic [31:0] cap [0:15][0:8];

    typedef struct {
        int          beat;
        int          fld;   // 0..3 WJ_i, 4..7 fj_i, 8 s
        logic [31:0] exp;
    } vec_t;
    vec_t tv [16];

    sm3_msg_expand dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(blk_ready), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .WJ_0(WJ_0), .WJ_1(WJ_1), .WJ_2(WJ_2), .WJ_3(WJ_3),
        .fj_0(fj_0), .fj_1(fj_1), .fj_2(fj_2), .fj_3(fj_3), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic void expand(input logic [511:0] b);
        logic [31:0] t;
        for (int j = 0; j < 16; j++) gw[j] = b[511 - 32*j -: 32];
        for (int j = 16; j < 68; j++) begin
            t = gw[j-16] ^ gw[j-9] ^ rl(gw[j-3], 15);
            gw[j] = t ^ rl(t, 15) ^ rl(t, 23) ^ rl(gw[j-13], 7) ^ gw[j-6];
        end
    endfunction

    function automatic logic [262:0] exp_beat(input int b);
        int j;
        j = 4 * b;
        return {7'(j), gw[j], gw[j+1], gw[j+2], gw[j+3],
                gw[j] ^ gw[j+4], gw[j+1] ^ gw[j+5], gw[j+2] ^ gw[j+6], gw[j+3] ^ gw[j+7]};
    endfunction

    task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Load one block, consume its 16 beats with out_ready high pct% of cycles,
    // then check the DONE cycle. Returns at the negedge inside the DONE cycle.
    task automatic run_block(input logic [511:0] b, input int pct, input bit ign,
                             input bit hold, input logic [511:0] bnext, input bit cap_en);
        int n, beat, cyc;
        expand(b);
        n = 0;
        while (!blk_ready && n < 40) begin @(negedge clk); n++; end
        chk("blk_ready_wait", 272'(blk_ready), 272'(1));
        blk_data  = b;
        blk_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        blk_valid = hold;
        if (hold) blk_data = bnext;
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 400) begin
            if (ign) begin
                blk_valid = (cyc == 3);
                blk_data  = ~b;
            end
            out_ready = ($urandom_range(99) < pct);
            chk("beat", {out_valid, blk_ready, s, WJ_0, WJ_1, WJ_2, WJ_3, fj_0, fj_1, fj_2, fj_3},
                {1'b1, 1'b0, exp_beat(beat)});
            if (cap_en && out_ready) begin
                cap[beat][0] = WJ_0; cap[beat][1] = WJ_1; cap[beat][2] = WJ_2; cap[beat][3] = WJ_3;
                cap[beat][4] = fj_0; cap[beat][5] = fj_1; cap[beat][6] = fj_2; cap[beat][7] = fj_3;
                cap[beat][8] = 32'(s);
            end
            if (out_ready) beat++;
            @(negedge clk);
            cyc++;
        end
        if (beat < 16) chk("beat_timeout", 272'(beat), 272'(16));
        out_ready = 1'b0;
        blk_valid = hold;
        chk("done_cycle", {done, out_valid, blk_ready, s}, {1'b1, 1'b0, 1'b0, 7'd64});
        blocks_done++;
    endtask

    logic [511:0] abc, b2, rb;
    int n;

    initial begin
        abc = {32'h61626380, 448'h0, 32'h00000018};
        b2  = {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafef00d, 384'h5a5a, 32'h11111111};

        tv[0]  = '{0, 8, 32'd0};
        tv[1]  = '{0, 0, 32'h61626380};
        tv[2]  = '{0, 1, 32'h0};
        tv[3]  = '{0, 3, 32'h0};
        tv[4]  = '{0, 4, 32'h61626380};
        tv[5]  = '{3, 8, 32'd12};
        tv[6]  = '{3, 3, 32'h00000018};
        tv[7]  = '{3, 4, 32'h9092e200};
        tv[8]  = '{3, 6, 32'h000c0606};
        tv[9]  = '{3, 7, 32'h719c70f5};
        tv[10] = '{4, 8, 32'd16};
        tv[11] = '{4, 0, 32'h9092e200};
        tv[12] = '{4, 1, 32'h0};
        tv[13] = '{4, 2, 32'h000c0606};
        tv[14] = '{4, 3, 32'h719c70ed};
        tv[15] = '{15, 8, 32'd60};

        // reset state
        #2;
        chk("reset_state", {blk_ready, out_valid, done, s, WJ_0, WJ_3, fj_0, fj_3},
            {1'b1, 1'b0, 1'b0, 7'd0, 128'h0});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {blk_ready, out_valid, done, s}, {1'b1, 1'b0, 1'b0, 7'd0});

        // "abc" with out_ready held high; captured beats checked against the table
        run_block(abc, 100, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("abc_vec%0d", i), 272'(cap[tv[i].beat][tv[i].fld]), 272'(tv[i].exp));
        @(negedge clk);
        chk("done_single", {done, blk_ready, s}, {1'b0, 1'b1, 7'd0});

        // backpressure
        run_block(abc, 45, 1'b0, 1'b0, '0, 1'b0);

        // back-to-back with blk_valid held
        run_block(abc, 100, 1'b0, 1'b1, b2, 1'b0);
        run_block(b2, 100, 1'b0, 1'b0, '0, 1'b0);

        // blk_valid pulsed with other data mid-run
        run_block(b2, 70, 1'b1, 1'b0, '0, 1'b0);

        // reset mid-block at s=28
        expand(abc);
        n = 0;
        while (!blk_ready && n < 40) begin @(negedge clk); n++; end
        blk_data  = abc;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && s == 7'd28) && n < 20) begin @(negedge clk); n++; end
        chk("reach_s28", {out_valid, s}, {1'b1, 7'd28});
        #2 rst = 1'b1;
        #1 chk("reset_mid", {out_valid, blk_ready, done, s, WJ_0, fj_3},
               {1'b0, 1'b1, 1'b0, 7'd0, 64'h0});
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_block(abc, 100, 1'b0, 1'b0, '0, 1'b0);

        // random blocks
        for (int k = 0; k < 1000; k++) begin
            for (int w = 0; w < 16; w++) rb[511 - 32*w -: 32] = $urandom;
            run_block(rb, 30 + $urandom_range(70), 1'b0, 1'b0, '0, 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("done_count", 272'(done_cnt), 272'(blocks_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
